// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   MULDIV_WIDTH : default operand/result width
//   op_e         : operation encodings (matches the 2-bit `op` port)
//   state_e      : sequencer states
//   op_ctl_t     : per-operation control flags latched at start
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Flags captured with the operands when a start is accepted.
  typedef struct packed {
    logic is_div;    // divide (1) or multiply (0)
    logic neg_res;   // product/quotient must be negated in FIX
    logic neg_rem;   // remainder takes the dividend's (negative) sign
    logic div_zero;  // divide with a zero divisor
  } op_ctl_t;

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate -- conditional two's-complement negate.
//   neg  : in  1 -- negate when high, pass through when low
//   din  : in  W -- value
//   dout : out W -- din or -din
// Used for operand magnitudes and for the sign fix of product,
// quotient and remainder.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MULT/MULTU/DIV/DIVU with HI/LO result registers.
//   clk, rstn      : clock, async active-low reset
//   start, op, a, b: launch an operation (sampled in IDLE only)
//   hi_wr, lo_wr,
//   wdata          : direct HI/LO write (IDLE only, start has priority)
//   busy           : high whenever not IDLE
//   done           : one-cycle pulse, hi/lo valid
//   hi, lo         : high product / remainder, low product / quotient
//   div0           : (MULDIV_DIV0_EN only) pulses with done on divide by zero
// Latency is WIDTH+2 cycles: WIDTH CALC iterations, one FIX, one DONE.
// With MULDIV_DIV0_EN defined a zero-divisor divide skips CALC and
// finishes in two cycles; results are identical either way.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state, state_nx;
  op_ctl_t            ctl_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q, a_q;
  logic [2*WIDTH-1:0] acc;   // mult: {partial, multiplier}; div: low half is dividend/quotient
  logic [WIDTH-1:0]   rem;   // divide partial remainder (always < divisor)
  logic [WIDTH-1:0]   hi_q, lo_q;

  // ---------------------------------------------------------------------
  // Operand decode and magnitudes
  // ---------------------------------------------------------------------
  logic             op_signed, op_div, a_neg, b_neg, skip_calc;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];

  muldiv_negate #(.W(WIDTH)) u_abs_a (.neg(a_neg), .din(a), .dout(abs_a));
  muldiv_negate #(.W(WIDTH)) u_abs_b (.neg(b_neg), .din(b), .dout(abs_b));

`ifdef MULDIV_DIV0_EN
  assign skip_calc = op_div && (b == '0);
`else
  assign skip_calc = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;  // WIDTH+1-bit partial remainder
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right by one.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a_q} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    // Restoring: bring in the next dividend bit, subtract if it fits.
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_ge    = div_shift >= {1'b0, mag_b_q};
  end

  // The difference is only kept when it fits, so its top bit is always 0.
  logic unused_div_msb;
  assign unused_div_msb = div_diff[WIDTH];

  // ---------------------------------------------------------------------
  // Sign fix
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (.neg(ctl_q.neg_res), .din(acc),            .dout(prod_fix));
  muldiv_negate #(.W(WIDTH))   u_fix_quo  (.neg(ctl_q.neg_res), .din(acc[WIDTH-1:0]), .dout(quo_fix));
  muldiv_negate #(.W(WIDTH))   u_fix_rem  (.neg(ctl_q.neg_rem), .din(rem),            .dout(rem_fix));

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = skip_calc ? S_FIX : S_CALC;
      end
      S_CALC:  if (cnt == CNT_LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef MULDIV_DIV0_EN
  assign div0 = done & ctl_q.div_zero;
`endif

  // ---------------------------------------------------------------------
  // Datapath and HI/LO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctl_q   <= '0;
      cnt     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      a_q     <= '0;
      acc     <= '0;
      rem     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ctl_q.is_div   <= op_div;
            ctl_q.neg_res  <= a_neg ^ b_neg;
            ctl_q.neg_rem  <= a_neg;
            ctl_q.div_zero <= op_div && (b == '0);
            mag_a_q        <= abs_a;
            mag_b_q        <= abs_b;
            a_q            <= a;
            cnt            <= '0;
            rem            <= '0;
            acc            <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
          end else begin
            if (hi_wr) hi_q <= wdata;
            if (lo_wr) lo_q <= wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt + CW'(1);
          if (ctl_q.is_div) begin
            rem <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_next;
          end
        end
        S_FIX: begin
          if (!ctl_q.is_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (ctl_q.div_zero) begin
            // Zero divisor: original dividend in HI, all-ones quotient.
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV0_EN
  localparam int DIV0_LAT = 2;
`else
  localparam int DIV0_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         start, hi_wr, lo_wr;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic         div0_w;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] r_hi, r_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIV0_EN
    , .div0(div0_w)
`endif
  );
`ifndef MULDIV_DIV0_EN
  assign div0_w = 1'b0;
`endif

  // Drive start for edge 0; returns at #1 into cycle 1.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded), records latency, busy cycles, results,
  // then steps one more cycle and samples busy there.
  task automatic wait_done(output int lat, output int bcnt, output logic bafter, output logic d0);
    lat = 0; bcnt = 0; d0 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        lat = c; r_hi = hi; r_lo = lo; d0 = div0_w;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bafter = busy;
  endtask

  task automatic direct_write(input logic wh, input logic wl, input logic [W-1:0] d);
    hi_wr = wh; lo_wr = wl; wdata = d;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
  endtask

  task automatic test_reset;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (hi !== '0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", hi); end
    vectors++; if (lo !== '0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", lo); end
    vectors++; if (div0_w !== 1'b0) begin miscompares++; $display("FAIL reset_div0: got %b want 0", div0_w); end
  endtask

  task automatic test_multu;
    int lat, bc; logic ba, d0;
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc, ba, d0);
    vectors++; if (lat != 34) begin miscompares++; $display("FAIL multu_latency: got %0d want 34", lat); end
    vectors++; if (r_hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h want fffffffe", r_hi); end
    vectors++; if (r_lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h want 00000001", r_lo); end
    vectors++; if (bc != 34) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d want 34", bc); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL multu_busy_after: got %b want 0", ba); end
  endtask

  task automatic test_mult;
    int lat, bc; logic ba, d0;
    logic [1:0]   ops [3] = '{OP_MULT, OP_MULT, OP_MULT};
    logic [W-1:0] xa  [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h00001234};
    logic [W-1:0] xb  [3] = '{32'h00000007, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] eh  [3] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF};
    logic [W-1:0] el  [3] = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFEDCC};
    for (int i = 0; i < 3; i++) begin
      launch(ops[i], xa[i], xb[i]);
      wait_done(lat, bc, ba, d0);
      vectors++; if (r_hi !== eh[i] || r_lo !== el[i]) begin
        miscompares++; $display("FAIL mult_%0d: got %h_%h want %h_%h", i, r_hi, r_lo, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div;
    int lat, bc; logic ba, d0;
    logic [1:0]   ops [5] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
    logic [W-1:0] xa  [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'd100};
    logic [W-1:0] xb  [5] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7};
    logic [W-1:0] eh  [5] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 32'd2};
    logic [W-1:0] el  [5] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'hFFFFFFFD, 32'h80000000, 32'd14};
    for (int i = 0; i < 5; i++) begin
      launch(ops[i], xa[i], xb[i]);
      wait_done(lat, bc, ba, d0);
      vectors++; if (r_hi !== eh[i] || r_lo !== el[i] || lat != 34) begin
        miscompares++; $display("FAIL div_%0d: got %h_%h lat %0d want %h_%h lat 34", i, r_hi, r_lo, lat, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc; logic ba, d0;
    logic exp_d0;
`ifdef MULDIV_DIV0_EN
    exp_d0 = 1'b1;
`else
    exp_d0 = 1'b0;
`endif
    launch(OP_DIVU, 32'd100, 32'd0);
    wait_done(lat, bc, ba, d0);
    vectors++; if (lat != DIV0_LAT) begin miscompares++; $display("FAIL divu0_latency: got %0d want %0d", lat, DIV0_LAT); end
    vectors++; if (r_hi !== 32'd100) begin miscompares++; $display("FAIL divu0_hi: got %h want 00000064", r_hi); end
    vectors++; if (r_lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divu0_lo: got %h want ffffffff", r_lo); end
    vectors++; if (d0 !== exp_d0) begin miscompares++; $display("FAIL divu0_flag: got %b want %b", d0, exp_d0); end
    launch(OP_DIV, 32'hFFFFFFFB, 32'd0);
    wait_done(lat, bc, ba, d0);
    vectors++; if (r_hi !== 32'hFFFFFFFB || r_lo !== 32'hFFFFFFFF || lat != DIV0_LAT) begin
      miscompares++; $display("FAIL div0_signed: got %h_%h lat %0d want fffffffb_ffffffff lat %0d", r_hi, r_lo, lat, DIV0_LAT);
    end
    // A normal multiply right after: no stale div0.
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done(lat, bc, ba, d0);
    vectors++; if (r_lo !== 32'd42 || d0 !== 1'b0) begin
      miscompares++; $display("FAIL after_div0: got lo %h div0 %b want 0000002a 0", r_lo, d0);
    end
  endtask

  task automatic test_direct_write;
    int lat, bc; logic ba, d0;
    direct_write(1'b1, 1'b0, 32'h12345678);
    vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL wr_hi: got %h want 12345678", hi); end
    direct_write(1'b0, 1'b1, 32'hCAFEF00D);
    vectors++; if (lo !== 32'hCAFEF00D || hi !== 32'h12345678) begin
      miscompares++; $display("FAIL wr_lo: got %h_%h want 12345678_cafef00d", hi, lo);
    end
    direct_write(1'b1, 1'b1, 32'h0BADBEEF);
    vectors++; if (hi !== 32'h0BADBEEF || lo !== 32'h0BADBEEF) begin
      miscompares++; $display("FAIL wr_both: got %h_%h want 0badbeef_0badbeef", hi, lo);
    end
    // start and hi_wr together: start wins, write dropped.
    hi_wr = 1'b1; wdata = 32'h55555555;
    launch(OP_MULTU, 32'd3, 32'd4);
    hi_wr = 1'b0;
    vectors++; if (hi !== 32'h0BADBEEF || busy !== 1'b1) begin
      miscompares++; $display("FAIL start_wins: got hi %h busy %b want 0badbeef 1", hi, busy);
    end
    wait_done(lat, bc, ba, d0);
    vectors++; if (r_hi !== 32'd0 || r_lo !== 32'd12) begin
      miscompares++; $display("FAIL start_wins_result: got %h_%h want 00000000_0000000c", r_hi, r_lo);
    end
  endtask

  task automatic test_busy_ignore;
    logic moved;
    int   lat;
    direct_write(1'b1, 1'b1, 32'hA5A5A5A5);
    launch(OP_MULT, 32'd3, 32'd5);
    moved = 1'b0; lat = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (c == 5) begin
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      end
      if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5 || busy !== 1'b1 || done !== 1'b0) moved = 1'b1;
      @(posedge clk); #1;
    end
    vectors++; if (moved !== 1'b0) begin miscompares++; $display("FAIL busy_hold: got disturbed hi/lo or busy want held"); end
    vectors++; if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
      miscompares++; $display("FAIL busy_result: got done %b %h_%h want 1 00000000_0000000f", done, hi, lo);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) lat++;
    end
    vectors++; if (lat != 0) begin miscompares++; $display("FAIL busy_no_relaunch: got %0d busy cycles want 0", lat); end
  endtask

  task automatic test_reset_mid;
    int seen;
    direct_write(1'b1, 1'b1, 32'h13579BDF);
    launch(OP_MULT, 32'hFFFFFFF0, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vectors++; if (hi !== '0 || lo !== '0) begin miscompares++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", hi, lo); end
    @(posedge clk); #1;
    rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_mid_nodone: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rstn = 1'b1;
    @(posedge clk); #1;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_direct_write;
    test_busy_ignore;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
